// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared constants for the 8-digit hex display scanner:
//                source-select encodings, digit count and segment glyphs.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Display source encodings carried on the mode input
    localparam logic [1:0] MODE_RF   = 2'd0;
    localparam logic [1:0] MODE_MEM  = 2'd1;
    localparam logic [1:0] MODE_PC   = 2'd2;
    localparam logic [1:0] MODE_INST = 2'd3;

    localparam int NUM_DIGITS = 8;

    // Active-low 7-segment hex glyphs, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Address-indexed sources get a decimal point marker on the rightmost digit
    function automatic logic dp_lit(input logic [1:0] m);
        return (m == MODE_RF) || (m == MODE_MEM);
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-flop synchroniser plus stability counter for one raw
//                push-button; emits a single-cycle pulse on each debounced
//                press (0->1 of the accepted level).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic [1:0]  sync_q;
    logic        level_q, level_d;
    logic        pulse_q, pulse_d;
    logic [31:0] cnt_q, cnt_d;

    // A differing sample that has persisted DB_CYC samples becomes the new level
    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == 32'(DB_CYC - 1)) begin
            level_d = sync_q[1];
            pulse_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Synchroniser and debounce state; reset discards any partial count
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg
//  Description : 4-bit hex value to active-low 7-segment glyph lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; no state
    assign seg_o = SEG_GLYPH[hex_i];

endmodule : hex7seg
`default_nettype wire

// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan
//  Description : 8-digit multiplexed hex display driver. Buttons step a
//                5-bit index used to address the register file / data
//                memory; a per-frame snapshot of the selected source is
//                scanned out one digit per CLK_DIV cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scan
    import disp_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int DB_CYC  = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic [4:0]  rf_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] rf_data,
    input  logic [31:0] mem_data,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_inst,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [4:0]  idx
);

    logic                  w_up_pulse, w_dn_pulse;
    logic [4:0]            idx_q, idx_d;
    logic [31:0]           presc_q, presc_d;
    logic [2:0]            dig_q, dig_d;
    logic [31:0]           snap_q, snap_d;
    logic [1:0]            mode_q, mode_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  w_presc_wrap, w_frame_wrap;
    logic [3:0]            w_nibble;
    logic [6:0]            w_glyph;
    logic [31:0]           w_src;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_up),
        .pulse_o (w_up_pulse)
    );

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_dn),
        .pulse_o (w_dn_pulse)
    );

    hex7seg u_hex (
        .hex_i (w_nibble),
        .seg_o (w_glyph)
    );

    assign w_presc_wrap = (presc_q == 32'(CLK_DIV - 1));
    assign w_frame_wrap = w_presc_wrap && (dig_q == 3'd7);
    assign w_nibble     = snap_q[{dig_q, 2'b00} +: 4];

    // Source mux feeding the snapshot; only sampled at a frame boundary
    always_comb begin
        w_src = rf_data;
        case (mode)
            MODE_RF:   w_src = rf_data;
            MODE_MEM:  w_src = mem_data;
            MODE_PC:   w_src = cpu_pc;
            MODE_INST: w_src = cpu_inst;
            default:   w_src = rf_data;
        endcase
    end

    // Index stepping, prescaler, digit scan and frame-consistent snapshot
    always_comb begin
        idx_d   = idx_q;
        presc_d = presc_q + 32'd1;
        dig_d   = dig_q;
        snap_d  = snap_q;
        mode_d  = mode_q;
        case ({w_up_pulse, w_dn_pulse})
            2'b10:   idx_d = idx_q + 5'd1;
            2'b01:   idx_d = idx_q - 5'd1;
            default: idx_d = idx_q;
        endcase
        if (w_presc_wrap) begin
            presc_d = '0;
            dig_d   = dig_q + 3'd1;
        end
        // Mode is latched with the data so the dp marker matches the frame
        if (w_frame_wrap) begin
            snap_d = w_src;
            mode_d = mode;
        end
        an_d  = ~(NUM_DIGITS'(1) << dig_q);
        seg_d = {~((dig_q == 3'd0) && dp_lit(mode_q)), w_glyph};
    end

    // State and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q   <= '0;
            presc_q <= '0;
            dig_q   <= '0;
            snap_q  <= '0;
            mode_q  <= MODE_RF;
            an_q    <= '1;
            seg_q   <= '1;
        end else begin
            idx_q   <= idx_d;
            presc_q <= presc_d;
            dig_q   <= dig_d;
            snap_q  <= snap_d;
            mode_q  <= mode_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign idx      = idx_q;
    assign rf_addr  = idx_q;
    assign mem_addr = {25'b0, idx_q, 2'b00};
    assign an       = an_q;
    assign seg      = seg_q;

endmodule : disp_scan
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_scan
//  Description : Scoreboard bench for disp_scan with a cycle-count based
//                reference model of the scan/snapshot behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan;

    localparam int CLK_DIV = 4;
    localparam int DB_CYC  = 3;
    localparam int FRAME   = CLK_DIV * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        btn_up, btn_dn;
    logic [4:0]  rf_addr;
    logic [31:0] mem_addr;
    logic [31:0] rf_data, mem_data, cpu_pc, cpu_inst;
    logic [7:0]  an, seg;
    logic [4:0]  idx;

    logic [31:0] rf_mem [32];
    logic [31:0] dmem   [32];

    assign rf_data  = rf_mem[rf_addr];
    assign mem_data = dmem[mem_addr[6:2]];

    disp_scan #(.CLK_DIV(CLK_DIV), .DB_CYC(DB_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .rf_addr  (rf_addr),
        .mem_addr (mem_addr),
        .rf_data  (rf_data),
        .mem_data (mem_data),
        .cpu_pc   (cpu_pc),
        .cpu_inst (cpu_inst),
        .an       (an),
        .seg      (seg),
        .idx      (idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Conventional active-high hex glyphs (a..g in bits 0..6)
    logic [6:0] glyph_ah [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
    } out_t;

    out_t        exp_q [$];
    int          exp_idx;
    int unsigned t_m;
    int          d_m;
    logic [31:0] snap_m;
    logic [1:0]  mode_m;
    logic [3:0]  nib_m;
    out_t        e_m;

    // Reference model: digit = (cycles since reset / CLK_DIV) mod 8; the
    // displayed word is whatever was selected at the last whole-frame mark.
    initial begin
        t_m = 0; snap_m = 0; mode_m = 2'd0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                e_m.an  = 8'hFF;
                e_m.seg = 8'hFF;
                t_m = 0; snap_m = 0; mode_m = 2'd0;
            end else begin
                d_m     = int'((t_m / CLK_DIV) % 8);
                nib_m   = 4'((snap_m >> (4 * d_m)) & 32'hF);
                e_m.an  = 8'hFF & ~(8'h01 << d_m);
                e_m.seg = {((d_m == 0) && (mode_m < 2'd2)) ? 1'b0 : 1'b1, ~glyph_ah[nib_m]};
                t_m++;
                if (t_m % FRAME == 0) begin
                    mode_m = mode;
                    case (mode)
                        2'd0:    snap_m = rf_mem[exp_idx];
                        2'd1:    snap_m = dmem[exp_idx];
                        2'd2:    snap_m = cpu_pc;
                        default: snap_m = cpu_inst;
                    endcase
                end
            end
            exp_q.push_back(e_m);
        end
    end

    // Monitor: the display presents a new digit state every cycle
    out_t got;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_empty: got output an=%h with no expectation", an);
            end else begin
                got = exp_q.pop_front();
                check("an", {24'b0, an}, {24'b0, got.an});
                check("seg", {24'b0, seg}, {24'b0, got.seg});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        btn_up = up;
        btn_dn = dn;
        cyc(hold);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cyc(10);
    endtask

    task automatic check_idx(input string name);
        check({name, "_idx"}, {27'b0, idx}, 32'(exp_idx));
        check({name, "_rf_addr"}, {27'b0, rf_addr}, 32'(exp_idx));
        check({name, "_mem_addr"}, mem_addr, 32'(exp_idx) << 2);
    endtask

    int k;
    int r;
    initial begin
        rst = 1'b0; mode = 2'd2; btn_up = 1'b0; btn_dn = 1'b0;
        cpu_pc = 32'h0040_00AC; cpu_inst = 32'hDEAD_BEEF;
        exp_idx = 0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = $urandom;
            dmem[i]   = $urandom;
        end
        cyc(5);
        check("reset_an", {24'b0, an}, 32'hFF);
        check("reset_seg", {24'b0, seg}, 32'hFF);
        check_idx("reset");
        rst = 1'b1;

        // Short glitch is rejected, a held press steps once
        press(1'b1, 1'b0, 2);
        check_idx("glitch");
        press(1'b1, 1'b0, 10);
        exp_idx = 1;
        check_idx("up1");
        press(1'b0, 1'b1, 10);
        exp_idx = 0;
        check_idx("dn0");
        press(1'b0, 1'b1, 10);
        exp_idx = 31;
        check_idx("wrap_dn");
        press(1'b1, 1'b0, 10);
        exp_idx = 0;
        check_idx("wrap_up");

        // Scan of cpu_pc over several frames
        cyc(3 * FRAME);

        // Tearing: source changes mid-frame must not show until next frame
        mode = 2'd0;
        rf_mem[0] = 32'h1234_5678;
        cyc(2 * FRAME + 3);
        k = 0;
        while (an !== 8'hF7 && k < 2 * FRAME) begin
            cyc(1);
            k++;
        end
        check("find_digit3", {24'b0, an}, 32'hF7);
        rf_mem[0] = 32'hFFFF_FFFF;
        cyc(2 * FRAME + 5);

        // Simultaneous presses cancel
        mode = 2'd2;
        press(1'b1, 1'b1, 10);
        check_idx("simul");

        // Random presses and glitches while showing cpu_pc
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: begin press(1'b1, 1'b0, 8); exp_idx = (exp_idx + 1) % 32; end
                1: begin press(1'b0, 1'b1, 8); exp_idx = (exp_idx + 31) % 32; end
                2: press(1'b1, 1'b1, 8);
                default: press(1'b1, 1'b0, 2);
            endcase
            check_idx("rand_btn");
        end

        // Random source/mode traffic with a fixed index
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: rf_mem[exp_idx] = $urandom;
                    1: dmem[exp_idx]   = $urandom;
                    2: cpu_pc          = $urandom;
                    default: cpu_inst  = $urandom;
                endcase
            end
        end

        // Reset mid-debounce and mid-frame
        mode = 2'd1;
        btn_up = 1'b1;
        cyc(4);
        rst = 1'b0;
        exp_idx = 0;
        @(posedge clk);
        #1;
        check("midreset_an", {24'b0, an}, 32'hFF);
        @(negedge clk);
        btn_up = 1'b0;
        rst = 1'b1;
        cyc(12);
        check_idx("after_reset");
        cyc(2 * FRAME + 7);

        cyc(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_disp_scan
`default_nettype wire

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 50000, giving the clock cycles per digit refresh slot.
REQ-002 The module SHALL have parameter DB_CYC, default 250000, giving the clock cycles a button must be stable to register.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port mode, input, 2 bits: source select; 0 = register file, 1 = data memory, 2 = cpu_pc, 3 = cpu_inst.
REQ-006 The module SHALL have ports btn_up and btn_dn, inputs, 1 bit each: raw, asynchronous push-buttons.
REQ-007 The module SHALL have port rf_addr, output, 5 bits: register file display address.
REQ-008 The module SHALL have port mem_addr, output, 32 bits: data memory display address.
REQ-009 The module SHALL have ports rf_data, mem_data, cpu_pc and cpu_inst, inputs, 32 bits each: the core's display data.
REQ-010 The module SHALL have port an, output, 8 bits: active-low digit enables; bit 0 is the rightmost digit.
REQ-011 The module SHALL have port seg, output, 8 bits: active-low segments a..g in bits 0..6 and the decimal point in bit 7.
REQ-012 The module SHALL have port idx, output, 5 bits: the current display index.

Function
REQ-013 Each button SHALL pass through a 2-flop synchroniser, then a debounce counter that accepts a new level only after DB_CYC consecutive equal samples.
REQ-014 A debounced 0->1 transition SHALL produce a one-cycle pulse.
REQ-015 An up pulse SHALL increment idx modulo 32 (31 wraps to 0), and a down pulse SHALL decrement it modulo 32 (0 wraps to 31).
REQ-016 If up and down pulses occur in the same cycle, idx SHALL be unchanged.
REQ-017 rf_addr SHALL equal idx combinationally.
REQ-018 mem_addr SHALL equal {25'b0, idx, 2'b00} combinationally (word addresses 0x00..0x7C).
REQ-019 A prescaler SHALL count 0..CLK_DIV-1 and wrap; at each wrap the 3-bit digit counter SHALL advance, wrapping 7 to 0.
REQ-020 The 32-bit snapshot register SHALL load the source selected by mode only in the cycle where the digit counter wraps 7 to 0, so a frame never shows mixed data.
REQ-021 A change of mode or idx SHALL take effect at the next frame boundary, not mid-frame.
REQ-022 an SHALL drive exactly one bit low, the bit matching the digit counter.
REQ-023 seg[6:0] SHALL show the hex glyph of snapshot nibble [4d+3:4d], where d is the digit counter, with 0-F rendered as 7-segment hex.
REQ-024 seg[7] SHALL be 0 (dp lit) only on digit 0 when mode is 0 or 1; otherwise it SHALL be 1.
REQ-025 an and seg SHALL be registered outputs, lagging the digit counter by one cycle.

Reset
REQ-026 When rst=0 at a clock edge, the module SHALL set idx=0, prescaler=0, digit counter=0, snapshot=0, an=8'hFF, seg=8'hFF, and clear the debounce counters and levels to 0.
REQ-027 A reset mid-debounce or mid-frame SHALL discard the partial count, and no pulse SHALL be generated by the reset itself.
REQ-028 After reset release, the first snapshot load SHALL occur at the first 7->0 digit wrap.

Structure
REQ-029 The shared package disp_pkg SHALL hold the mode encodings (MODE_RF, MODE_MEM, MODE_PC, MODE_INST), NUM_DIGITS=8, and the 16-entry segment glyph constant.
REQ-030 Hex-to-segment decoding SHALL be a sub-module named hex7seg (4-bit in, 7-bit active-low out).
REQ-031 The two button channels SHALL use one debounce instance each of a sub-module named btn_debounce.

Verification (CLK_DIV=4, DB_CYC=3)
REQ-032 Reset: hold rst=0 for 5 cycles -> an=FF, seg=FF, idx=0, mem_addr=0.
REQ-033 Debounce: pulse btn_up high 2 cycles -> idx stays 0; hold 10 cycles -> idx=1 exactly once; mem_addr=0x4.
REQ-034 Wrap: from idx=0, one debounced down press -> idx=31, rf_addr=31, mem_addr=0x7C; then an up press -> idx=0.
REQ-035 Scan: mode=2, cpu_pc=0x0040_00AC -> after the frame boundary, digits 0..7 show C,A,0,0,0,4,0,0, with each an bit low for 4 cycles, in order, and dp off.
REQ-036 Tearing: change rf_data 0x1234_5678 -> 0xFFFF_FFFF during digit 3 with mode=0 -> the remaining digits still show 1,2,3,4, and the next frame shows all F with dp on digit 0.
REQ-037 Simultaneous: btn_up and btn_dn debounced in the same cycle -> idx unchanged; assert rst mid-frame -> an=FF on the next cycle.
